// File: rtl/keypad_scan_ctrl.sv
// Row-scan keypad controller: drives one row low at a time, debounces full-frame
// snapshots, and queues the code of every newly pressed key in a small valid/ready FIFO.
module keypad_scan_ctrl #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 6,
  parameter int unsigned SETTLE_CYC      = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] key_in,
  output logic [ROWS-1:0] key_out,
  output logic [4:0]      key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            any_key,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int unsigned NK = ROWS * COLS;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {ST_DRIVE, ST_COMPARE, ST_EMIT} state_t;

  logic [COLS-1:0] sync1_q, sync2_q, pressed;
  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NK-1:0]   frame_q, frame_d, last_q, last_d;
  logic [NK-1:0]   deb_q, deb_d, pend_q, pend_d;
  logic [NK-1:0]   emit_mask;
  logic [4:0]      emit_idx;
  logic [3:0]      stable_q, stable_d;
  logic [ROWS-1:0] key_out_q, key_out_d;
  logic            any_key_q, any_key_d;
  logic            ovf_q, ovf_d;
  logic            push, push_ok, pop, full, drop;
  logic [4:0]      push_code;
  logic [4:0]      mem_q [FIFO_DEPTH];
  logic [4:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  assign pressed = ~sync2_q;

  // Lowest pending key isolated as a one-hot mask, then converted to its index.
  always_comb begin
    emit_mask = pend_q & (~pend_q + NK'(1));
    emit_idx  = '0;
    for (int unsigned i = 0; i < NK; i++) begin
      if (emit_mask[i]) emit_idx = 5'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    last_d    = last_q;
    deb_d     = deb_q;
    pend_d    = pend_q;
    stable_d  = stable_q;
    push      = 1'b0;
    push_code = '0;
    case (state_q)
      ST_DRIVE: begin
        if (cnt_q == 8'(SETTLE_CYC - 1)) begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_q == RW'(r)) frame_d[r*COLS +: COLS] = pressed;
          end
          cnt_d = '0;
          if (row_q == RW'(ROWS - 1)) state_d = ST_COMPARE;
          else                        row_d   = row_q + RW'(1);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_COMPARE: begin
        if (frame_q == last_q) stable_d = (stable_q == 4'hF) ? 4'hF : stable_q + 4'd1;
        else                   stable_d = '0;
        last_d = frame_q;
        row_d  = '0;
        cnt_d  = '0;
        if (stable_d == 4'(DEBOUNCE_FRAMES - 1)) begin
          pend_d  = frame_q & ~deb_q;
          deb_d   = frame_q;
          state_d = ST_EMIT;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_EMIT: begin
        if (pend_q == '0) begin
          state_d = ST_DRIVE;
        end else begin
          push      = 1'b1;
          push_code = emit_idx;
          pend_d    = pend_q & ~emit_mask;
        end
      end
      default: state_d = ST_DRIVE;
    endcase
  end

  // Row drive is registered from the next state so reset and idle both show all ones.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      key_out_d[r] = !((state_d == ST_DRIVE) && (row_d == RW'(r)));
    end
    any_key_d = |deb_d;
  end

  always_comb begin
    pop     = (count_q != '0) && key_ready;
    full    = (count_q == CW'(FIFO_DEPTH));
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_q] = push_code;
    wr_d = wr_q;
    if (push_ok) wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    rd_d = rd_q;
    if (pop) rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      state_q   <= ST_DRIVE;
      row_q     <= '0;
      cnt_q     <= '0;
      frame_q   <= '0;
      last_q    <= '0;
      deb_q     <= '0;
      pend_q    <= '0;
      stable_q  <= '0;
      key_out_q <= '1;
      any_key_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      deb_q     <= deb_d;
      pend_q    <= pend_d;
      stable_q  <= stable_d;
      key_out_q <= key_out_d;
      any_key_q <= any_key_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_code  = mem_q[rd_q];
  assign key_valid = (count_q != '0);
  assign any_key   = any_key_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Row-scan sequencer for the 4x6 key matrix. It drives one row low at a time on key_out and samples the active-low key_in columns. Each full-frame snapshot is debounced, and every newly pressed key is encoded into a 5-bit code. Codes are buffered in a small FIFO with a valid/ready interface, which the display/decoder logic consumes for the LEDs.

Parameters:
ROWS, 4, number of matrix rows driven (key_out width)
COLS, 6, number of matrix columns sensed (key_in width)
SETTLE_CYC, 8, clock cycles each row is driven before sampling; legal range 4..255
DEBOUNCE_FRAMES, 3, consecutive identical frames required before the debounced matrix updates; legal range 1..15
FIFO_DEPTH, 4, key-code FIFO entries; power of two

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_in  input  COLS  column sense lines, active-low (0 = pressed on the driven row), asynchronous
key_out  output  ROWS  row drive, active-low one-cold; all ones when idle or in reset
key_code  output  5  FIFO head: row*COLS+col, range 0..23
key_valid  output  1  FIFO non-empty
key_ready  input  1  consumer accepts key_code when key_valid && key_ready
any_key  output  1  debounced matrix has at least one key pressed
overflow  output  1  sticky: a code was dropped because the FIFO was full
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release): key_out=all ones, key_valid=0, key_code=0, any_key=0, overflow=0; FIFO empty; FSM=DRIVE at row 0; settle counter, frame buffer, debounced matrix and stable counter all cleared.
- key_in passes through a 2-flop synchronizer. Pressed = ~key_in_sync.
- FSM states:
  - DRIVE: key_out=~(1<<row). Settle counter runs 0..SETTLE_CYC-1. On count SETTLE_CYC-1, capture pressed into frame[row*COLS +: COLS]. If row<ROWS-1: row++, counter=0, stay in DRIVE. Otherwise go to COMPARE.
  - COMPARE (1 cycle, key_out=all ones):
    - If frame==last_frame: stable=min(stable+1,15); otherwise stable=0.
    - last_frame<=frame.
    - If stable reaches DEBOUNCE_FRAMES-1 (i.e. this is the DEBOUNCE_FRAMES-th identical frame): pending<=frame & ~debounced, debounced<=frame, go to EMIT. Otherwise go to DRIVE at row 0.
  - EMIT: each cycle, priority-encode the lowest set bit of pending, push its index, clear that bit. When pending==0, go to DRIVE at row 0. With pending==0 on entry, EMIT lasts 1 cycle.
- Frame period with no emission: ROWS*SETTLE_CYC+1 cycles; default 33.
- Release events are not reported. A key held across many frames is reported once. Re-press after a debounced release is reported again.
- any_key = |debounced, registered.
- FIFO:
  - Pop on key_valid && key_ready. Push from EMIT.
  - Simultaneous push and pop when full: both succeed, no drop.
  - Push when full without pop: code dropped and overflow<=1.
  - ovf_clr coincident with a drop: overflow stays 1 (set wins).
  - key_code is the registered head; valid one cycle after the push lands in an empty FIFO.
- Latency from stable press to key_valid: at most 2 sync + (DEBOUNCE_FRAMES+1) frames + EMIT position + 1.
- Simultaneous new presses in one debounced frame are emitted in ascending code order, one per cycle.
- Glitches shorter than DEBOUNCE_FRAMES frames never change debounced and produce no code.

Test Plan:
- Reset mid-scan (rst_n low while row 2 is driven) -> key_out=4'b1111 immediately; key_valid=0; after release, scan restarts at row 0 with key_out=4'b1110.
- Hold key_in=6'b101111 only while row 0 is driven (column 4) for 5 frames -> exactly one code 4, key_valid high, any_key=1; no second code while held.
- Press row 1 col 0 and row 3 col 5 together, stable -> codes 6 then 23 on consecutive pops; release all -> any_key=0, no codes; re-press row 1 col 0 -> code 6 again.
- Column 2 low on row 2 for 2 frames only, default DEBOUNCE_FRAMES=3 -> no code, any_key stays 0.
- key_ready=0, press 5 distinct keys in sequence -> 4 codes queued in order, overflow=1. Pulse ovf_clr -> overflow=0. Drain -> first 4 codes, key_valid falls after the 4th pop.
- FIFO full with key_ready=1 on the same cycle as an EMIT push -> no drop, overflow stays 0, count unchanged.
